// File: rtl/utmi_pkg.sv
// ============================================================================
// utmi_pkg - shared types and constants for the UTMI transmit sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package utmi_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    LOAD = 3'd2,
    DATA = 3'd3,
    EOP  = 3'd4,
    GAP  = 3'd5
  } tx_state_t;

  localparam logic [7:0] SYNC_PATTERN       = 8'h80;
  localparam int         GAP_CYCLES_DEFAULT = 4;
  localparam int         GAP_CNT_W          = 4;

endpackage

`default_nettype wire

// File: rtl/utmi_tx_watchdog.sv
// ============================================================================
// utmi_tx_watchdog - loadable saturating counter with clear/enable and expiry
// Revision: 1.0
// ============================================================================
`default_nettype none

module utmi_tx_watchdog #(
  parameter int WIDTH = 11,
  parameter int LIMIT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  localparam logic [WIDTH-1:0] LIMIT_VAL = WIDTH'(LIMIT);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count < LIMIT_VAL)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count >= LIMIT_VAL);

endmodule

`default_nettype wire

// File: rtl/utmi_tx_ctrl.sv
// ============================================================================
// utmi_tx_ctrl - UTMI transmit packet sequencer (SYNC / data load / EOP / gap)
// Optional watchdog abort compiled in with UTMI_TX_WATCHDOG_EN. Revision: 1.0
// ============================================================================
`default_nettype none

module utmi_tx_ctrl
  import utmi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int GAP_CYCLES     = GAP_CYCLES_DEFAULT
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       TxValid,
  input  logic [7:0] DataIn,
  output logic       TxReady,
  input  logic       sync_done,
  input  logic       TX_hold_empty,
  input  logic       EOP_done,
  output logic       sync_enable,
  output logic       load_data_enable,
  output logic [7:0] DataOut,
  output logic       EOP_enable,
  output logic       tx_active,
  output logic       tx_error
);

  tx_state_t            state;
  tx_state_t            next_state;
  logic [GAP_CNT_W-1:0] gap_cnt;
  logic                 wd_abort;

  if ((GAP_CYCLES < 1) || (GAP_CYCLES > 15) || (TIMEOUT_CYCLES < 1)) begin : g_bad_params
    $error("utmi_tx_ctrl: GAP_CYCLES must be 1..15 and TIMEOUT_CYCLES >= 1");
  end

`ifdef UTMI_TX_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic wd_count_en;
  logic wd_expired;
  logic wd_clear;

  assign wd_count_en = (state == SYNC) || (state == DATA) || (state == EOP);
  assign wd_clear    = (next_state != state);

  utmi_tx_watchdog #(
    .WIDTH (WD_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk        (Clk),
    .rst        (Rst),
    .clear      (wd_clear),
    .enable     (wd_count_en),
    .load       (1'b0),
    .load_value ({WD_W{1'b0}}),
    .expired    (wd_expired)
  );

  assign wd_abort = wd_expired && wd_count_en;
`else
  assign wd_abort = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (TxValid && (gap_cnt == '0)) next_state = SYNC;
      SYNC: if (sync_done) next_state = TxValid ? LOAD : EOP;
      LOAD: next_state = DATA;
      // TxValid sampled with TX_hold_empty decides whether another byte follows
      DATA: if (TX_hold_empty) next_state = TxValid ? LOAD : EOP;
      EOP:  if (EOP_done) next_state = GAP;
      GAP:  if (gap_cnt == '0) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (wd_abort) begin
      next_state = GAP;
    end
  end

  always_comb begin
    sync_enable      = 1'b0;
    load_data_enable = 1'b0;
    TxReady          = 1'b0;
    EOP_enable       = 1'b0;
    tx_active        = 1'b0;
    tx_error         = wd_abort;
    case (state)
      SYNC: begin
        sync_enable = !wd_abort;
        tx_active   = 1'b1;
      end
      LOAD: begin
        load_data_enable = 1'b1;
        TxReady          = 1'b1;
        tx_active        = 1'b1;
      end
      DATA: tx_active = 1'b1;
      EOP: begin
        EOP_enable = !wd_abort;
        tx_active  = 1'b1;
      end
      default: ;
    endcase
  end

  // Capture on the edge into LOAD so DataOut is valid alongside TxReady
  always_ff @(posedge Clk) begin
    if (Rst) begin
      DataOut <= 8'h00;
    end else if (next_state == LOAD) begin
      DataOut <= DataIn;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      gap_cnt <= '0;
    end else if ((state != GAP) && (next_state == GAP)) begin
      gap_cnt <= GAP_CNT_W'(GAP_CYCLES - 1);
    end else if ((state == GAP) && (gap_cnt != '0)) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: doc/utmi_tx_ctrl.md
# utmi_tx_ctrl

Transmit sequencer for the UTMI serialiser: sits between the SIE byte interface (TxValid/DataIn/TxReady) and the shift/hold register. Drives the SYNC, data-load and EOP phases, paces byte hand-off from the SIE, and enforces an inter-packet gap. It owns the packet-level sequencing, while the shift/hold register owns bit timing and stuffing.

## Interface
- TIMEOUT_CYCLES, 1024: watchdog limit per phase, in Clk cycles (only with watchdog compiled in).
- GAP_CYCLES, 4: idle cycles enforced after EOP before a new SYNC may start; legal range 1–15.
- Clk  in  1  transmit clock; the only clock.
- Rst  in  1  synchronous, active-high reset.
- TxValid  in  1  SIE has a byte/packet to send.
- DataIn  in  8  SIE byte; stable while TxValid=1 until TxReady.
- TxReady  out  1  one-cycle pulse: DataIn captured this cycle.
- sync_done  in  1  from shift/hold register: SYNC byte shifted.
- TX_hold_empty  in  1  from shift/hold register: hold byte consumed.
- EOP_done  in  1  from shift/hold register: EOP pattern finished.
- sync_enable  out  1  request SYNC pattern load.
- load_data_enable  out  1  one-cycle pulse: load DataOut into hold register.
- DataOut  out  8  captured byte for the hold register.
- EOP_enable  out  1  request EOP pattern.
- tx_active  out  1  packet in progress (SYNC through EOP).
- tx_error  out  1  one-cycle pulse on watchdog abort.

## Operation
- Reset: state IDLE, all outputs 0, DataOut=8'h00, gap counter 0.
- States and transitions:
  - IDLE: when TxValid=1 and gap counter=0, go to SYNC.
  - SYNC: hold sync_enable=1 and tx_active=1. On sync_done, sample TxValid. If it is 1, go to LOAD. If it is 0 (SIE withdrew before the first byte), go to EOP.
  - LOAD: single cycle. DataOut<=DataIn, TxReady=1, load_data_enable=1 on the next edge; then go to DATA.
  - DATA: wait for TX_hold_empty. On it, TxValid=1 goes to LOAD; TxValid=0 goes to EOP.
  - EOP: hold EOP_enable=1 until EOP_done, then go to GAP.
  - GAP: tx_active=0, load the gap counter with GAP_CYCLES-1, count down to 0, then go to IDLE.
- TxReady is asserted exactly once per accepted byte, never in SYNC, EOP or GAP.
- TxValid falling in the middle of a byte (in DATA): the current byte finishes, then the sequencer goes to EOP. No byte is dropped or repeated.
- TxValid and TX_hold_empty rising in the same cycle in DATA: the TxValid value sampled on that edge decides the next state.
- sync_done or EOP_done arriving in an unexpected state is ignored.
- Rst asserted mid-packet: next edge forces IDLE with all outputs 0. The gap is not enforced after reset.

## Timing
- TxValid sampled 1 in IDLE gives sync_enable=1 on the following edge (1-cycle latency).
- sync_done gives TxReady/load_data_enable 1 cycle later (LOAD), with DataOut valid the same cycle.
- TX_hold_empty gives the next TxReady 1 cycle later.
- A nominal byte with no stuffing takes 32 Clk (bit every 4th Clk), so TxReady pulses are ≥32 cycles apart.
- From EOP_done to earliest next sync_enable: GAP_CYCLES+2 cycles.
- Counters are 4-bit for the gap and ceil(log2(TIMEOUT_CYCLES+1)) bits for the watchdog; neither wraps, both saturate.

## Configuration
- UTMI_TX_WATCHDOG_EN defined:
  - The watchdog counter clears on every state change and counts in SYNC, DATA and EOP.
  - On reaching TIMEOUT_CYCLES: tx_error pulses, all enables drop, and the FSM goes to GAP.
- UTMI_TX_WATCHDOG_EN undefined: no counter; tx_error is tied to 0; the FSM waits indefinitely.

## Structure
- Shared package utmi_pkg: state enumeration typedef (IDLE, SYNC, LOAD, DATA, EOP, GAP), SYNC pattern constant 8'h80, default GAP_CYCLES.
- One sub-module, utmi_tx_watchdog: a loadable saturating counter with clear, enable and an expired flag. It is instantiated only under UTMI_TX_WATCHDOG_EN.

## Test plan
- Single byte 8'hA5: TxValid=1 and held until TxReady, then 0 → sync_enable, one TxReady, DataOut=8'hA5, EOP_enable until EOP_done, tx_active low after EOP.
- Three bytes 8'h01, 8'h02, 8'h03 back-to-back → three TxReady pulses, each 1 cycle after sync_done/TX_hold_empty; bytes loaded in order; single EOP.
- TxValid dropped during SYNC → no TxReady, EOP follows sync_done.
- New TxValid immediately after EOP_done with GAP_CYCLES=4 → sync_enable rises exactly 6 cycles after EOP_done.
- Rst pulsed in DATA → next cycle all outputs 0, state IDLE; a new packet starts normally.
- Watchdog build with TIMEOUT_CYCLES=16 and TX_hold_empty withheld → tx_error pulse after 16 cycles in DATA, then GAP and IDLE; non-watchdog build keeps waiting with tx_error=0.
